// File: rtl/ahb_arbiter_if.sv
// Arbitration-side view of the AHB-Lite bus: master requests/locks, the muxed
// transfer info of the current owner, and the arbiter's grant/ownership outputs.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = 2
);
  // A cycle is "accepted" when HREADY is 1 at the rising edge; every arbiter
  // register advances only on accepted cycles and holds otherwise.
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic [MW-1:0]          HMASTER_D;
  logic                   HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter: one-hot grant, address/data-phase owner tracking,
// and burst/lock protection against handover.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb_arbiter_if.slave  bus,
  output logic [1:0]    dbg_state_o,
  output logic [3:0]    dbg_burst_rem_o
);

  typedef enum logic [1:0] {
    ST_DEFAULT = 2'd0,
    ST_GRANTED = 2'd1,
    ST_BURST   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_e                 state_q, state_d;
  logic [MW-1:0]          owner_q, owner_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          mast_q, mast_d;
  logic [MW-1:0]          mast_dp_q, mast_dp_d;
  logic                   mastlock_q, mastlock_d;
  logic [3:0]             rem_q, rem_d;

  logic                   owner_lock;
  logic                   arb_point;
  logic                   found;
  logic [MW-1:0]          next_owner;
  logic [MW-1:0]          cand;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_DEFAULT;
      owner_q    <= DEF_IDX;
      grant_q    <= onehot(DEF_IDX);
      mast_q     <= DEF_IDX;
      mast_dp_q  <= DEF_IDX;
      mastlock_q <= 1'b0;
      rem_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      mast_q     <= mast_d;
      mast_dp_q  <= mast_dp_d;
      mastlock_q <= mastlock_d;
      rem_q      <= rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    mast_d     = mast_q;
    mast_dp_d  = mast_dp_q;
    mastlock_d = mastlock_q;
    rem_d      = rem_q;
    found      = 1'b0;
    next_owner = DEF_IDX;
    cand       = '0;

    owner_lock = bus.HLOCK[owner_q];
    arb_point  = bus.HREADY && (rem_q == 4'd0) && !owner_lock;

    // Search owner+1 .. owner+N so the current owner is considered last.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = MW'((int'(owner_q) + k) % NUM_MASTERS);
      if (!found && bus.HBUSREQ[cand]) begin
        found      = 1'b1;
        next_owner = cand;
      end
    end

    if (bus.HREADY) begin
      mast_dp_d  = mast_q;
      mast_d     = owner_q;
      mastlock_d = owner_lock;

      case (bus.HTRANS)
        TR_NONSEQ: begin
          case (bus.HBURST)
            3'd2, 3'd3: rem_d = 4'd3;
            3'd4, 3'd5: rem_d = 4'd7;
            3'd6, 3'd7: rem_d = 4'd15;
            default:    rem_d = 4'd0;
          endcase
        end
        TR_SEQ:  rem_d = (rem_q == 4'd0) ? 4'd0 : rem_q - 4'd1;
        TR_IDLE: rem_d = 4'd0;
        default: rem_d = rem_q;
      endcase

      if (arb_point) begin
        owner_d = found ? next_owner : DEF_IDX;
      end

      if (arb_point && !found) begin
        state_d = ST_DEFAULT;
      end else if (rem_d != 4'd0) begin
        state_d = ST_BURST;
      end else if (!arb_point && owner_lock) begin
        state_d = ST_LOCKED;
      end else begin
        state_d = ST_GRANTED;
      end
    end

    grant_d = onehot(owner_d);
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = mast_q;
  assign bus.HMASTER_D = mast_dp_q;
  assign bus.HMASTLOCK = mastlock_q;

  assign dbg_state_o     = state_q;
  assign dbg_burst_rem_o = rem_q;

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter for the AHB-Lite memory slave. It lets up to NUM_MASTERS requesters share the single address/data path. It issues one-hot grants, tracks address-phase and data-phase ownership so external muxes can steer HADDR/control/HWDATA, and protects fixed-length bursts and locked sequences from handover. It sits between the masters and the slave, observing the muxed HTRANS/HBURST and the slave's HREADY.

## Interface
- NUM_MASTERS, 4: number of requesters, 2..8.
- MW, 2: width of master index, ≥ clog2(NUM_MASTERS).
- DEFAULT_MASTER, 0: master granted when no request is pending.

Ports:
- HCLK  in  1  bus clock, all state on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HBUSREQ  in  NUM_MASTERS  per-master request, level.
- HLOCK  in  NUM_MASTERS  per-master lock request.
- HTRANS  in  2  muxed transfer type of current address-phase owner.
- HBURST  in  3  muxed burst type of current owner.
- HREADY  in  1  bus ready (slave HREADYout).
- HGRANT  out  NUM_MASTERS  registered one-hot grant.
- HMASTER  out  MW  address-phase owner index (address/control mux select).
- HMASTER_D  out  MW  data-phase owner index (HWDATA mux select).
- HMASTLOCK  out  1  current address phase is locked.

## Operation
- Reset values: HGRANT = one-hot(DEFAULT_MASTER); HMASTER = HMASTER_D = DEFAULT_MASTER; HMASTLOCK = 0; burst_rem = 0; state = DEFAULT.
- "Accepted" means a cycle with HREADY=1 at the rising edge.
- Beat counter burst_rem (4 bits):
  - Accepted NONSEQ: load beats−1, i.e. 3 for HBURST 2/3, 7 for 4/5, 15 for 6/7, and 0 for SINGLE/INCR.
  - Accepted SEQ: decrement, saturating at 0.
  - Accepted IDLE: clear to 0 (early termination).
  - BUSY: hold.
- State machine (grant owner = index of HGRANT):
  - DEFAULT: no requests; DEFAULT_MASTER granted.
  - GRANTED: owner granted, arbitration open.
  - BURST: burst_rem ≠ 0; grant frozen.
  - LOCKED: HLOCK[owner]=1; grant frozen.
- Arbitration point: accepted cycle with burst_rem = 0 (value before the edge update) and HLOCK[owner] = 0.
  - At that point, HGRANT <= first requester searching owner+1, owner+2, … wrapping, with owner checked last.
  - If no requester, HGRANT <= DEFAULT_MASTER and state goes to DEFAULT.
- Outside an arbitration point, HGRANT holds. HREADY=0 always freezes HGRANT, HMASTER, HMASTER_D, HMASTLOCK and burst_rem.
- Ownership registers, updated on each accepted cycle:
  - HMASTER_D <= HMASTER.
  - HMASTER <= index(HGRANT).
  - HMASTLOCK <= HLOCK[index(HGRANT)].
- Lock: while HLOCK[owner] stays high, no handover, even with burst_rem = 0. Release takes effect at the first arbitration point after HLOCK[owner] falls.
- HBUSREQ deasserted by the owner mid-burst does not shorten the burst; handover waits for burst_rem = 0.
- Simultaneous: a new NONSEQ accepted in the same cycle as an arbitration point reloads burst_rem. The grant change still occurs, and the new owner's first NONSEQ reloads the counter.
- HBUSREQ bits at or above NUM_MASTERS are ignored.

## Timing
- Request-to-ownership with HREADY=1 throughout: HBUSREQ high before edge E0 → HGRANT at E0 → HMASTER at E1 → HMASTER_D at E2. That is 2 cycles to address phase and 3 to data phase.
- Burst handover: the old master's last SEQ is accepted at edge Ek. HGRANT changes at Ek+1; the old master drives IDLE for that cycle. HMASTER changes at Ek+2.
- Wait states (HREADY=0) stretch every step one-for-one; no output changes in a stalled cycle.
- Reset asserted mid-burst: all outputs return to their reset values immediately (async); burst_rem clears.
- All outputs are registered; none depends combinationally on inputs.

## Test plan
- Reset: after HRESETn rise with no requests → HGRANT=4'b0001, HMASTER=0, HMASTER_D=0, HMASTLOCK=0, stable for 10 cycles.
- Round-robin: HBUSREQ=4'b1111 held, SINGLE NONSEQ every cycle, HREADY=1 → grants 1,2,3,0,1… each held 1 cycle; HMASTER lags HGRANT by 1 cycle, HMASTER_D lags by 2.
- Burst protection: master 1 issues INCR8 (HBURST=5), master 2 requesting → HGRANT stays 1 until 7 SEQ beats are accepted, then goes to 2 on the next edge; with HREADY low for 3 cycles mid-burst, handover is delayed by exactly 3 cycles.
- Early termination: WRAP4 with IDLE after 2 beats → burst_rem clears and HGRANT moves on the following accepted edge.
- Lock: master 3 with HLOCK=1 performs 3 SINGLE transfers while master 0 requests → no grant change and HMASTLOCK=1 during those address phases; HLOCK falls → grant goes to 0 at the next arbitration point and HMASTLOCK returns to 0.
- Async reset: HRESETn pulsed low mid-INCR16 → outputs return to reset values the same cycle; no grant glitch after release.
